// File: rtl/ssd1306_i2c_target.sv
// Write-only I2C target for the SSD1306 receive path: decodes START/STOP, matches ADDR, ACKs,
// splits control bytes from command/data bytes. Events act 3 clk after the pin changes; no backpressure.
module ssd1306_i2c_target #(
  parameter logic [6:0] ADDR = 7'h3C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_is_data,
  output logic       busy,
  output logic       frame_end
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_CTRL,
    S_CTRL_ACK,
    S_DATA,
    S_DATA_ACK,
    S_IGNORE
  } state_t;

  state_t      state_q, state_d;
  logic        scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_h_q, scl_h_d;
  logic        sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_h_q, sda_h_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        byte_full_q, byte_full_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        co_q, co_d;
  logic        dc_q, dc_d;
  logic        sda_oe_q, sda_oe_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_is_data_q, rx_is_data_d;
  logic        busy_q, busy_d;
  logic        frame_end_q, frame_end_d;

  logic scl_rise, scl_fall, start_ev, stop_ev, rx_state;

  // Open-drain: only ever pull low; the async reset clears sda_oe_q without a clock.
  assign sda = sda_oe_q ? 1'b0 : 1'bz;

  assign rx_byte    = rx_byte_q;
  assign rx_valid   = rx_valid_q;
  assign rx_is_data = rx_is_data_q;
  assign busy       = busy_q;
  assign frame_end  = frame_end_q;

  assign scl_rise = scl_s2_q & ~scl_h_q;
  assign scl_fall = ~scl_s2_q & scl_h_q;
  assign start_ev = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign stop_ev  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
  assign rx_state = (state_q == S_ADDR) || (state_q == S_CTRL) || (state_q == S_DATA);

  always_comb begin
    scl_s1_d = scl;
    scl_s2_d = scl_s1_q;
    scl_h_d  = scl_s2_q;
    sda_s1_d = sda;
    sda_s2_d = sda_s1_q;
    sda_h_d  = sda_s2_q;
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    byte_full_d  = byte_full_q;
    shreg_d      = shreg_q;
    co_d         = co_q;
    dc_d         = dc_q;
    sda_oe_d     = sda_oe_q;
    rx_byte_d    = rx_byte_q;
    rx_valid_d   = 1'b0;
    rx_is_data_d = rx_is_data_q;
    busy_d       = busy_q;
    frame_end_d  = 1'b0;

    if (stop_ev) begin
      state_d     = S_IDLE;
      sda_oe_d    = 1'b0;
      bit_cnt_d   = 3'd0;
      byte_full_d = 1'b0;
      busy_d      = 1'b0;
      frame_end_d = busy_q;
    end else if (start_ev) begin
      // busy is only re-evaluated once the new address byte is complete
      state_d     = S_ADDR;
      sda_oe_d    = 1'b0;
      bit_cnt_d   = 3'd0;
      byte_full_d = 1'b0;
    end else if (rx_state && scl_rise) begin
      shreg_d   = {shreg_q[6:0], sda_s2_q};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_full_d = 1'b1;
      end
    end else if (scl_fall) begin
      case (state_q)
        S_ADDR: begin
          if (byte_full_q) begin
            byte_full_d = 1'b0;
            if (shreg_q == {ADDR, 1'b0}) begin
              state_d  = S_ADDR_ACK;
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
            end else begin
              state_d     = S_IGNORE;
              busy_d      = 1'b0;
              frame_end_d = busy_q;
            end
          end
        end
        S_ADDR_ACK: begin
          sda_oe_d = 1'b0;
          state_d  = S_CTRL;
        end
        S_CTRL: begin
          if (byte_full_q) begin
            byte_full_d = 1'b0;
            co_d        = shreg_q[7];
            dc_d        = shreg_q[6];
            sda_oe_d    = 1'b1;
            state_d     = S_CTRL_ACK;
          end
        end
        S_CTRL_ACK: begin
          sda_oe_d = 1'b0;
          state_d  = S_DATA;
        end
        S_DATA: begin
          if (byte_full_q) begin
            byte_full_d  = 1'b0;
            rx_byte_d    = shreg_q;
            rx_is_data_d = dc_q;
            rx_valid_d   = 1'b1;
            sda_oe_d     = 1'b1;
            state_d      = S_DATA_ACK;
          end
        end
        S_DATA_ACK: begin
          sda_oe_d = 1'b0;
          state_d  = co_q ? S_CTRL : S_DATA;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      scl_s1_q     <= 1'b1;
      scl_s2_q     <= 1'b1;
      scl_h_q      <= 1'b1;
      sda_s1_q     <= 1'b1;
      sda_s2_q     <= 1'b1;
      sda_h_q      <= 1'b1;
      bit_cnt_q    <= 3'd0;
      byte_full_q  <= 1'b0;
      shreg_q      <= 8'd0;
      co_q         <= 1'b0;
      dc_q         <= 1'b0;
      sda_oe_q     <= 1'b0;
      rx_byte_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      rx_is_data_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_end_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      scl_s1_q     <= scl_s1_d;
      scl_s2_q     <= scl_s2_d;
      scl_h_q      <= scl_h_d;
      sda_s1_q     <= sda_s1_d;
      sda_s2_q     <= sda_s2_d;
      sda_h_q      <= sda_h_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_full_q  <= byte_full_d;
      shreg_q      <= shreg_d;
      co_q         <= co_d;
      dc_q         <= dc_d;
      sda_oe_q     <= sda_oe_d;
      rx_byte_q    <= rx_byte_d;
      rx_valid_q   <= rx_valid_d;
      rx_is_data_q <= rx_is_data_d;
      busy_q       <= busy_d;
      frame_end_q  <= frame_end_d;
    end
  end

endmodule

// File: tb/tb_ssd1306_i2c_target.sv
// Bench for ssd1306_i2c_target: bit-banged I2C initiator, scoreboard of expected received bytes.
module tb_ssd1306_i2c_target;

  localparam int T = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       sda_drv_low;
  wire        sda;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_is_data;
  logic       busy;
  logic       frame_end;

  int n_chk  = 0;
  int n_pass = 0;
  int fe_cnt = 0;
  logic [8:0] sb_q[$];

  pullup (sda);
  assign sda = sda_drv_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  ssd1306_i2c_target #(.ADDR(7'h3C)) dut (
    .clk        (clk),
    .rst        (rst),
    .scl        (scl),
    .sda        (sda),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .rx_is_data (rx_is_data),
    .busy       (busy),
    .frame_end  (frame_end)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Scoreboard side: every strobe must match the oldest pushed byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_end) fe_cnt++;
      if (rx_valid) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected", {24'd0, rx_byte}, 32'hFFFF_FFFF);
        end else begin
          logic [8:0] e;
          e = sb_q.pop_front();
          chk("rx_byte", {24'd0, rx_byte}, {24'd0, e[7:0]});
          chk("rx_is_data", {31'd0, rx_is_data}, {31'd0, e[8]});
        end
      end
    end
  end

  task automatic push(input logic is_data, input logic [7:0] b);
    sb_q.push_back({is_data, b});
  endtask

  task automatic i2c_start();
    sda_drv_low = 1'b1; #(T);
    scl = 1'b0;         #(T);
  endtask

  task automatic i2c_rep_start();
    sda_drv_low = 1'b0; #(T);
    scl = 1'b1;         #(T);
    sda_drv_low = 1'b1; #(T);
    scl = 1'b0;         #(T);
  endtask

  task automatic i2c_stop();
    sda_drv_low = 1'b1; #(T);
    scl = 1'b1;         #(T);
    sda_drv_low = 1'b0; #(2*T);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_drv_low = ~b[i]; #(T);
      scl = 1'b1;          #(2*T);
      scl = 1'b0;          #(T);
    end
  endtask

  task automatic i2c_wr(input logic [7:0] b, input logic exp_ack, input string tag);
    logic ack;
    send_bits(b, 8);
    sda_drv_low = 1'b0; #(T);
    scl = 1'b1;         #(T);
    ack = (sda === 1'b0);
    #(T);
    scl = 1'b0;         #(T);
    chk(tag, {31'd0, ack}, {31'd0, exp_ack});
  endtask

  initial begin
    int fe0;
    rst = 1'b1; scl = 1'b1; sda_drv_low = 1'b0;
    #(4*T);
    rst = 1'b0;
    #(2*T);
    chk("rst_sda", {31'd0, sda}, 32'd1);
    chk("rst_rx_byte", {24'd0, rx_byte}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_rx_is_data", {31'd0, rx_is_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_end", {31'd0, frame_end}, 32'd0);

    // Command stream
    fe0 = fe_cnt;
    i2c_start();
    i2c_wr(8'h78, 1'b1, "cmd_addr_ack");
    chk("cmd_busy", {31'd0, busy}, 32'd1);
    i2c_wr(8'h00, 1'b1, "cmd_ctrl_ack");
    push(1'b0, 8'hAE); i2c_wr(8'hAE, 1'b1, "cmd_ae_ack");
    push(1'b0, 8'hAF); i2c_wr(8'hAF, 1'b1, "cmd_af_ack");
    i2c_stop();
    chk("cmd_busy_end", {31'd0, busy}, 32'd0);
    chk("cmd_frame_end", fe_cnt - fe0, 32'd1);

    // Data stream
    fe0 = fe_cnt;
    i2c_start();
    i2c_wr(8'h78, 1'b1, "dat_addr_ack");
    i2c_wr(8'h40, 1'b1, "dat_ctrl_ack");
    push(1'b1, 8'hFF); i2c_wr(8'hFF, 1'b1, "dat_ff_ack");
    push(1'b1, 8'h81); i2c_wr(8'h81, 1'b1, "dat_81_ack");
    push(1'b1, 8'h00); i2c_wr(8'h00, 1'b1, "dat_00_ack");
    i2c_stop();
    chk("dat_frame_end", fe_cnt - fe0, 32'd1);

    // Co=1 interleave: each control byte covers exactly one byte
    i2c_start();
    i2c_wr(8'h78, 1'b1, "co_addr_ack");
    i2c_wr(8'h80, 1'b1, "co_ctrl1_ack");
    push(1'b0, 8'hA1); i2c_wr(8'hA1, 1'b1, "co_a1_ack");
    i2c_wr(8'hC0, 1'b1, "co_ctrl2_ack");
    push(1'b1, 8'h55); i2c_wr(8'h55, 1'b1, "co_55_ack");
    i2c_stop();
    chk("co_sb_drained", sb_q.size(), 32'd0);

    // Wrong address, then read request, then a good frame
    fe0 = fe_cnt;
    i2c_start();
    i2c_wr(8'h7A, 1'b0, "wrong_addr_nack");
    chk("wrong_busy", {31'd0, busy}, 32'd0);
    i2c_stop();
    i2c_start();
    i2c_wr(8'h79, 1'b0, "read_nack");
    chk("read_busy", {31'd0, busy}, 32'd0);
    i2c_stop();
    chk("nack_no_frame_end", fe_cnt - fe0, 32'd0);
    i2c_start();
    i2c_wr(8'h78, 1'b1, "after_addr_ack");
    i2c_wr(8'h00, 1'b1, "after_ctrl_ack");
    push(1'b0, 8'h8D); i2c_wr(8'h8D, 1'b1, "after_8d_ack");
    i2c_stop();

    // STOP mid-byte discards the partial byte
    fe0 = fe_cnt;
    i2c_start();
    i2c_wr(8'h78, 1'b1, "abort_addr_ack");
    i2c_wr(8'h00, 1'b1, "abort_ctrl_ack");
    send_bits(8'h12, 4);
    i2c_stop();
    chk("abort_frame_end", fe_cnt - fe0, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);

    // Repeated START mid-byte, then re-address
    fe0 = fe_cnt;
    i2c_start();
    i2c_wr(8'h78, 1'b1, "rs_addr_ack");
    i2c_wr(8'h00, 1'b1, "rs_ctrl_ack");
    send_bits(8'h34, 4);
    scl = 1'b0; #(T);
    i2c_rep_start();
    i2c_wr(8'h78, 1'b1, "rs_readdr_ack");
    chk("rs_busy", {31'd0, busy}, 32'd1);
    i2c_wr(8'h00, 1'b1, "rs_ctrl2_ack");
    push(1'b0, 8'hE3); i2c_wr(8'hE3, 1'b1, "rs_e3_ack");
    i2c_stop();
    chk("rs_frame_end", fe_cnt - fe0, 32'd1);

    // Async reset while the target holds the ACK
    i2c_start();
    i2c_wr(8'h78, 1'b1, "ar_addr_ack");
    i2c_wr(8'h00, 1'b1, "ar_ctrl_ack");
    push(1'b0, 8'hAE);
    send_bits(8'hAE, 8);
    sda_drv_low = 1'b0; #(T);
    scl = 1'b1;         #(T);
    chk("ar_ack_held", {31'd0, sda}, 32'd0);
    rst = 1'b1;
    #1;
    chk("ar_sda_released", {31'd0, sda}, 32'd1);
    chk("ar_rx_byte", {24'd0, rx_byte}, 32'd0);
    chk("ar_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("ar_rx_is_data", {31'd0, rx_is_data}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_frame_end", {31'd0, frame_end}, 32'd0);
    #(T);
    rst = 1'b0;
    #(T);
    scl = 1'b0; #(T);
    fe0 = fe_cnt;
    i2c_rep_start();
    i2c_wr(8'h78, 1'b1, "post_addr_ack");
    i2c_wr(8'h40, 1'b1, "post_ctrl_ack");
    push(1'b1, 8'h5A); i2c_wr(8'h5A, 1'b1, "post_5a_ack");
    i2c_stop();
    chk("post_frame_end", fe_cnt - fe0, 32'd1);
    chk("post_busy", {31'd0, busy}, 32'd0);

    #(4*T);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
